accumulator_serial_rx: RTL and testbench

//  Receive end of the accumulator serial readout link: deserialises the PAD_serialStart/PAD_serialOut

---
 rtl/accumulator_serial_rx.sv | 118 +++++++++++
 tb/tb_accumulator_serial_rx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_serial_rx.sv
// Receive end of the accumulator serial readout link: turns the start-marked, MSB-first
// serial stream into parallel count words with per-word, per-frame and abort pulses.
`timescale 1ns/1ps

module accumulator_serial_rx #(
  parameter int WORD_WIDTH      = 16,
  parameter int NUM_WORDS       = 4,
  parameter int IDX_WIDTH       = 2,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       serialClk,
  input  logic                       serialReset,
  input  logic                       rxEnable,
  input  logic                       serialStart,
  input  logic                       serialIn,
  output logic [WORD_WIDTH-1:0]      wordOut,
  output logic [IDX_WIDTH-1:0]       wordIndex,
  output logic                       wordValid,
  output logic                       frameDone,
  output logic                       frameError,
  output logic [FRAME_CNT_WIDTH-1:0] frameCount,
  output logic                       busy
);

  localparam int BIT_W = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0] WORD_LAST = IDX_WIDTH'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                     state, state_next;
  logic [WORD_WIDTH-2:0]      shreg, shreg_next;
  logic [BIT_W-1:0]           bit_cnt, bit_cnt_next;
  logic [IDX_WIDTH-1:0]       word_cnt, word_cnt_next;
  logic [WORD_WIDTH-1:0]      word_next;
  logic [IDX_WIDTH-1:0]       index_next;
  logic                       valid_next, done_next, error_next;
  logic [FRAME_CNT_WIDTH-1:0] count_next;
  logic [WORD_WIDTH-1:0]      shift_word;

  // Word as it stands once the bit currently on serialIn is shifted in.
  assign shift_word = {shreg, serialIn};
  assign busy       = (state == SHIFT);

  always_ff @(posedge serialClk or posedge serialReset) begin
    if (serialReset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      wordOut    <= '0;
      wordIndex  <= '0;
      wordValid  <= 1'b0;
      frameDone  <= 1'b0;
      frameError <= 1'b0;
      frameCount <= '0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      bit_cnt    <= bit_cnt_next;
      word_cnt   <= word_cnt_next;
      wordOut    <= word_next;
      wordIndex  <= index_next;
      wordValid  <= valid_next;
      frameDone  <= done_next;
      frameError <= error_next;
      frameCount <= count_next;
    end
  end

  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    bit_cnt_next  = bit_cnt;
    word_cnt_next = word_cnt;
    word_next     = wordOut;
    index_next    = wordIndex;
    valid_next    = 1'b0;
    done_next     = 1'b0;
    error_next    = 1'b0;
    count_next    = frameCount;
    unique case (state)
      IDLE: begin
        if (serialStart && rxEnable) begin
          state_next    = SHIFT;
          bit_cnt_next  = '0;
          word_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (serialStart) begin
          // Premature start aborts the frame and is itself the new start bit.
          error_next    = 1'b1;
          bit_cnt_next  = '0;
          word_cnt_next = '0;
        end else begin
          shreg_next = shift_word[WORD_WIDTH-2:0];
          if (bit_cnt == BIT_LAST) begin
            word_next     = shift_word;
            index_next    = word_cnt;
            valid_next    = 1'b1;
            bit_cnt_next  = '0;
            word_cnt_next = word_cnt + IDX_WIDTH'(1);
            if (word_cnt == WORD_LAST) begin
              done_next  = 1'b1;
              count_next = frameCount + FRAME_CNT_WIDTH'(1);
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_accumulator_serial_rx.sv
// Randomised bench for accumulator_serial_rx: frames are driven bit by bit and every pulse is
// compared against events predicted from whole-frame rules held in an expected queue.
`timescale 1ns/1ps

module tb_accumulator_serial_rx;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int FW = 8;
  localparam int EW = W + IW + 3;

  logic          clk = 1'b0;
  logic          rst, en, start, sin;
  logic [W-1:0]  wordOut;
  logic [IW-1:0] wordIndex;
  logic          wordValid, frameDone, frameError, busy;
  logic [FW-1:0] frameCount;

  int total = 0;
  int bad   = 0;

  // Event encoding: {wordValid, frameError, frameDone, wordIndex, wordOut}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] sb_obs, sb_exp;
  logic [FW-1:0] exp_fc;
  logic [W-1:0]  last_word;
  logic [IW-1:0] last_idx;
  logic [W-1:0]  fw[N];

  accumulator_serial_rx #(
    .WORD_WIDTH(W), .NUM_WORDS(N), .IDX_WIDTH(IW), .FRAME_CNT_WIDTH(FW)
  ) dut (
    .serialClk  (clk),
    .serialReset(rst),
    .rxEnable   (en),
    .serialStart(start),
    .serialIn   (sin),
    .wordOut    (wordOut),
    .wordIndex  (wordIndex),
    .wordValid  (wordValid),
    .frameDone  (frameDone),
    .frameError (frameError),
    .frameCount (frameCount),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  always @(negedge clk) begin
    if (!rst && (wordValid || frameDone || frameError)) begin
      sb_obs = {wordValid, frameError, frameDone, wordIndex, wordOut};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_pulse: got %h, required no pulse", sb_obs);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_obs !== sb_exp) begin
          bad++;
          $display("FAIL sb_event: got %h, required %h", sb_obs, sb_exp);
        end
      end
    end
  end

  // reference model: a frame that delivered nbits data bits before ending or being aborted
  task automatic model_frame(input int nbits, input bit aborted);
    for (int i = 0; i < N && i < nbits / W; i++) begin
      exp_q.push_back({1'b1, 1'b0, (i == N - 1), IW'(i), fw[i]});
      last_word = fw[i];
      last_idx  = IW'(i);
      if (i == N - 1) exp_fc = exp_fc + 1'b1;
    end
    if (aborted) exp_q.push_back({1'b0, 1'b1, 1'b0, last_idx, last_word});
  endtask

  // drivers
  task automatic drive(input logic s, input logic d);
    @(negedge clk);
    start = s;
    sin   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom));
  endtask

  task automatic send_bits(input int nbits);
    for (int b = 0; b < nbits; b++) drive(1'b0, fw[b / W][W - 1 - (b % W)]);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) fw[i] = W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; sin = 1'b0;
    exp_fc = '0; last_word = '0; last_idx = '0;
    #1;
    total++;
    if (wordOut !== '0) begin bad++; $display("FAIL reset_word: got %h, required 0", wordOut); end
    total++;
    if (frameCount !== '0) begin bad++; $display("FAIL reset_count: got %0d, required 0", frameCount); end
    total++;
    if ({wordIndex, wordValid, frameDone, frameError, busy} !== '0) begin
      bad++;
      $display("FAIL reset_flags: got %b, required 0",
               {wordIndex, wordValid, frameDone, frameError, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    en = 1'b1;
    fw[0] = 16'hA5C3; fw[1] = 16'h0001; fw[2] = 16'hFFFF; fw[3] = 16'h8000;
    model_frame(N * W, 1'b0);
    drive(1'b1, 1'b0);
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_high: got %b, required 1", busy); end
    send_bits(N * W);
    @(posedge clk); #1;
    total++;
    if (frameDone !== 1'b1 || wordIndex !== 2'd3) begin
      bad++;
      $display("FAIL basic_done: got done=%b idx=%0d, required done=1 idx=3", frameDone, wordIndex);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_low: got %b, required 0", busy); end
    total++;
    if (frameCount !== 8'd1) begin bad++; $display("FAIL basic_count: got %0d, required 1", frameCount); end
    idle(3);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL basic_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    logic [W-1:0] word0;
    rand_frame();
    word0 = fw[0];
    model_frame(W + 10, 1'b1);
    drive(1'b1, 1'b0);
    send_bits(W + 10);
    drive(1'b1, 1'($urandom));
    @(posedge clk); #1;
    total++;
    if (frameError !== 1'b1 || wordValid !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse: got err=%b valid=%b, required err=1 valid=0", frameError, wordValid);
    end
    total++;
    if (wordOut !== word0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_hold: got word=%h busy=%b, required word=%h busy=1", wordOut, busy, word0);
    end
    rand_frame();
    model_frame(N * W, 1'b0);
    send_bits(N * W);
    idle(3);
    total++;
    if (frameCount !== exp_fc || exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_recover: got count=%0d pending=%0d, required count=%0d pending=0",
               frameCount, exp_q.size(), exp_fc);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      rand_frame();
      model_frame(N * W, 1'b0);
      drive(1'b1, 1'($urandom));
      send_bits(N * W);
    end
    idle(3);
    total++;
    if (frameCount !== exp_fc || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b: got count=%0d pending=%0d, required count=%0d pending=0",
               frameCount, exp_q.size(), exp_fc);
    end
  endtask

  task automatic test_rx_disable();
    int busy_bad = 0;
    en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom));
      @(posedge clk); #1;
      if (busy !== 1'b0) busy_bad++;
    end
    total++;
    if (busy_bad != 0) begin bad++; $display("FAIL disabled_busy: got %0d busy cycles, required 0", busy_bad); end
    en = 1'b1;
    rand_frame();
    model_frame(N * W, 1'b0);
    drive(1'b1, 1'b0);
    @(posedge clk); #1;
    en = 1'b0;
    send_bits(N * W);
    idle(3);
    en = 1'b1;
    total++;
    if (frameCount !== exp_fc || exp_q.size() != 0) begin
      bad++;
      $display("FAIL enable_frame: got count=%0d pending=%0d, required count=%0d pending=0",
               frameCount, exp_q.size(), exp_fc);
    end
  endtask

  task automatic test_reset_mid();
    rand_frame();
    model_frame(2 * W, 1'b0);
    drive(1'b1, 1'b0);
    send_bits(2 * W + 5);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL midreset_pre: got %0d pending, required 0", exp_q.size()); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({wordOut, wordIndex, frameCount} !== '0) begin
      bad++;
      $display("FAIL midreset_data: got word=%h idx=%0d count=%0d, required 0 0 0", wordOut, wordIndex, frameCount);
    end
    total++;
    if ({wordValid, frameDone, frameError, busy} !== 4'b0) begin
      bad++;
      $display("FAIL midreset_flags: got %b, required 0000", {wordValid, frameDone, frameError, busy});
    end
    exp_fc = '0; last_word = '0; last_idx = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rand_frame();
    model_frame(N * W, 1'b0);
    drive(1'b1, 1'b0);
    send_bits(N * W);
    idle(3);
    total++;
    if (frameCount !== 8'd1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL midreset_after: got count=%0d pending=%0d, required count=1 pending=0", frameCount, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit need_start = 1'b1;
    int k;
    for (int it = 0; it < 10; it++) begin
      rand_frame();
      if (need_start) drive(1'b1, 1'($urandom));
      if (it == 0)                               k = 0;
      else if (it == 1)                          k = N * W - 1;
      else if (it < 9 && $urandom_range(0, 2) == 0) k = $urandom_range(0, N * W - 1);
      else                                       k = N * W;
      if (k < N * W) begin
        model_frame(k, 1'b1);
        send_bits(k);
        drive(1'b1, 1'($urandom));
        need_start = 1'b0;
      end else begin
        model_frame(N * W, 1'b0);
        send_bits(N * W);
        idle($urandom_range(0, 3));
        need_start = 1'b1;
      end
    end
    idle(3);
    total++;
    if (frameCount !== exp_fc || exp_q.size() != 0) begin
      bad++;
      $display("FAIL random: got count=%0d pending=%0d, required count=%0d pending=0",
               frameCount, exp_q.size(), exp_fc);
    end
  endtask

  task automatic test_wrap();
    while (exp_fc != 8'd255) begin
      rand_frame();
      model_frame(N * W, 1'b0);
      drive(1'b1, 1'($urandom));
      send_bits(N * W);
    end
    idle(2);
    total++;
    if (frameCount !== 8'd255) begin bad++; $display("FAIL wrap_pre: got %0d, required 255", frameCount); end
    rand_frame();
    model_frame(N * W, 1'b0);
    drive(1'b1, 1'b0);
    send_bits(N * W);
    @(posedge clk); #1;
    total++;
    if (frameDone !== 1'b1 || frameCount !== 8'd0) begin
      bad++;
      $display("FAIL wrap: got done=%b count=%0d, required done=1 count=0", frameDone, frameCount);
    end
    idle(3);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_abort();
    test_back_to_back();
    test_rx_disable();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
